// File: rtl/ab_parallel_enforcer_ctrl.sv
// Arbitration/sequencing controller merging the policy_a and policy_b enforcer outputs.
// Resolves disagreements by selectable priority, tracks consecutive conflicts and forces a
// safe lockout after CONFLICT_LIMIT of them until software clears it.
// Optional macro AB_CTRL_STATS_EN adds per-policy saturating recovery counters.
module ab_parallel_enforcer_ctrl #(
  parameter int unsigned CONFLICT_LIMIT = 3,
  parameter int unsigned CNT_W          = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick_in,
  input  logic             A_ctp_pa,
  input  logic             B_ctp_pa,
  input  logic [1:0]       rec_pa,
  input  logic             A_ctp_pb,
  input  logic             B_ctp_pb,
  input  logic [1:0]       rec_pb,
  input  logic             priority_b,
  input  logic             clear_lockout,
  output logic             A_ctp_out,
  output logic             B_ctp_out,
  output logic [1:0]       rec_out,
  output logic             tick_out,
  output logic             conflict,
  output logic             lockout,
  output logic [CNT_W-1:0] conflict_cnt
`ifdef AB_CTRL_STATS_EN
  ,
  output logic [CNT_W-1:0] rec_cnt_a,
  output logic [CNT_W-1:0] rec_cnt_b
`else
  // Recovery statistics ports absent in this build.
`endif
);

  typedef enum logic [1:0] {StNormal, StConflict, StLockout} state_e;

  localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

  state_e           state_q, state_d;
  logic [7:0]       run_q, run_d;
  logic [8:0]       run_inc;
  logic             a_q, a_d, b_q, b_d;
  logic [1:0]       rec_q, rec_d;
  logic             tick_q;
  logic             conf_q, conf_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             is_conf;
  logic             in_lock;

  assign is_conf = (A_ctp_pa != A_ctp_pb) || (B_ctp_pa != B_ctp_pb);
  assign in_lock = (state_q == StLockout);
  assign run_inc = {1'b0, run_q} + 9'd1;

  // Next-state and conflict-run tracking.
  always_comb begin
    state_d = state_q;
    run_d   = run_q;
    unique case (state_q)
      StNormal: begin
        if (tick_in && is_conf) begin
          run_d   = 8'd1;
          state_d = (CONFLICT_LIMIT == 1) ? StLockout : StConflict;
        end
      end
      StConflict: begin
        if (tick_in) begin
          if (!is_conf) begin
            state_d = StNormal;
            run_d   = 8'd0;
          end else begin
            run_d = run_inc[7:0];
            if (run_inc == 9'(CONFLICT_LIMIT)) state_d = StLockout;
          end
        end
      end
      StLockout: begin
        // Ticks never move the FSM out of lockout; only the clear does.
        if (clear_lockout) begin
          state_d = StNormal;
          run_d   = 8'd0;
        end
      end
      default: begin
        state_d = StNormal;
        run_d   = 8'd0;
      end
    endcase
  end

  // Output merge, conflict flag and conflict counter; all hold between ticks.
  always_comb begin
    a_d    = a_q;
    b_d    = b_q;
    rec_d  = rec_q;
    conf_d = conf_q;
    cnt_d  = cnt_q;
    if (tick_in) begin
      conf_d = is_conf;
      if (is_conf && (cnt_q != CntMax)) cnt_d = cnt_q + CntOne;
      if (in_lock) begin
        // Lockout applies even when a clear arrives with this tick.
        a_d   = 1'b0;
        b_d   = 1'b0;
        rec_d = 2'd0;
      end else if (is_conf && priority_b) begin
        a_d   = A_ctp_pb;
        b_d   = B_ctp_pb;
        rec_d = rec_pb;
      end else begin
        a_d   = A_ctp_pa;
        b_d   = B_ctp_pa;
        rec_d = rec_pa;
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StNormal;
      run_q   <= 8'd0;
      a_q     <= 1'b0;
      b_q     <= 1'b0;
      rec_q   <= 2'd0;
      tick_q  <= 1'b0;
      conf_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      run_q   <= run_d;
      a_q     <= a_d;
      b_q     <= b_d;
      rec_q   <= rec_d;
      tick_q  <= tick_in;
      conf_q  <= conf_d;
      cnt_q   <= cnt_d;
    end
  end

  assign A_ctp_out    = a_q;
  assign B_ctp_out    = b_q;
  assign rec_out      = rec_q;
  assign tick_out     = tick_q;
  assign conflict     = conf_q;
  assign lockout      = in_lock;
  assign conflict_cnt = cnt_q;

`ifdef AB_CTRL_STATS_EN
  logic [CNT_W-1:0] rca_q, rcb_q;

  // Saturating per-policy recovery counters, counted in every state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rca_q <= '0;
      rcb_q <= '0;
    end else if (tick_in) begin
      if ((rec_pa != 2'd0) && (rca_q != CntMax)) rca_q <= rca_q + CntOne;
      if ((rec_pb != 2'd0) && (rcb_q != CntMax)) rcb_q <= rcb_q + CntOne;
    end
  end

  assign rec_cnt_a = rca_q;
  assign rec_cnt_b = rcb_q;
`else
  // No recovery statistics in this build.
`endif

endmodule

// File: doc/ab_parallel_enforcer_ctrl.md
# ab_parallel_enforcer_ctrl

Arbitration and sequencing controller for the two parallel runtime enforcers of the `ab` example (policy_a and policy_b). Each synchronous reaction tick it merges both enforcers' edited `A_ctp`/`B_ctp` outputs into one final output pair. It resolves disagreements by a selectable priority and tracks consecutive conflicts. After a run of conflicts it forces a safe lockout until software clears it. It sits between the two enforcer output stages and the plant.

## Interface
- `CONFLICT_LIMIT`, 3: consecutive conflicting ticks that trigger lockout (legal range 1..255).
- `CNT_W`, 8: width of the saturating statistics counters.

- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `tick_in`  in  1  reaction-instant strobe; every other input is sampled only when this is 1.
- `A_ctp_pa`, `B_ctp_pa`  in  1 each  policy_a enforced outputs.
- `rec_pa`  in  2  policy_a recovery ref; 0 = no recovery this tick.
- `A_ctp_pb`, `B_ctp_pb`  in  1 each  policy_b enforced outputs.
- `rec_pb`  in  2  policy_b recovery ref.
- `priority_b`  in  1  on conflict: 1 selects policy_b, 0 selects policy_a.
- `clear_lockout`  in  1  single-cycle pulse; leaves LOCKOUT.
- `A_ctp_out`, `B_ctp_out`  out  1 each  registered final outputs.
- `rec_out`  out  2  registered recovery ref of the selected policy.
- `tick_out`  out  1  `tick_in` delayed one cycle; marks when the outputs are fresh.
- `conflict`  out  1  registered; the last tick disagreed.
- `lockout`  out  1  state == LOCKOUT.
- `conflict_cnt`  out  CNT_W  total conflicting ticks, saturating.
- `rec_cnt_a`, `rec_cnt_b`  out  CNT_W  recovery counts; present only when the stats macro is defined.

## Operation
- Agree on a tick: `A_ctp_pa==A_ctp_pb` and `B_ctp_pa==B_ctp_pb`. Otherwise the tick is a conflict.
- Merge on a tick:
  - Agree: outputs take the policy_a values, `rec_out`=`rec_pa`.
  - Conflict: outputs take the selected policy's values and its rec ref.
  - LOCKOUT: `A_ctp_out`=`B_ctp_out`=0 and `rec_out`=0, regardless of inputs.
- FSM states are NORMAL, CONFLICT, LOCKOUT. An 8-bit run counter `run` tracks consecutive conflicts.
  - NORMAL, conflict tick: `run`=1. Go to LOCKOUT if `CONFLICT_LIMIT`==1, else to CONFLICT.
  - CONFLICT, agree tick: go to NORMAL, `run`=0.
  - CONFLICT, conflict tick: `run`+1. Go to LOCKOUT when `run`+1 == `CONFLICT_LIMIT`, else stay.
  - LOCKOUT: ignore ticks for transitions. On `clear_lockout` go to NORMAL, `run`=0.
- `clear_lockout` outside LOCKOUT has no effect.
- If `clear_lockout` and `tick_in` arrive in the same cycle in LOCKOUT:
  - the clear wins;
  - the tick is merged as a LOCKOUT tick (outputs 0);
  - the next state is NORMAL.
- `conflict_cnt` increments on every conflicting tick in every state, saturating at 2^CNT_W−1.
- Between ticks, all outputs hold their values, except `tick_out`, which returns to 0.

## Timing
- Latency: the tick sampled at edge n produces outputs, `conflict` and `tick_out`=1 after edge n, valid for the cycle following edge n.
- `lockout` rises in that same cycle as the limit-reaching conflict tick's outputs.
- That limit-reaching tick itself still outputs the priority-selected values; lockout forcing starts with the next tick.
- Reset (asynchronous assert, synchronous deassert):
  - all outputs 0;
  - state NORMAL, `run`=0;
  - all counters 0.
- Reset mid-run discards the run and the lockout. The first tick after reset is treated as coming from NORMAL.
- Back-to-back ticks on consecutive cycles are supported with no bubbles.

## Configuration
- `AB_CTRL_STATS_EN` defined:
  - `rec_cnt_a` / `rec_cnt_b` are present;
  - each increments on a tick where `rec_pa` / `rec_pb` ≠ 0, in all states, saturating.
- Undefined: those counter registers and ports are removed. All other behaviour is identical.

## Test plan
- Reset, then tick with pa=pb=(1,0), `rec_pa`=`rec_pb`=0 → next cycle `A_ctp_out`=1, `B_ctp_out`=0, `tick_out`=1, `conflict`=0, state NORMAL.
- Tick with pa=(1,0), pb=(0,0), `rec_pb`=2, `priority_b`=1 → outputs (0,0), `rec_out`=2, `conflict`=1, `conflict_cnt`=1.
- With `CONFLICT_LIMIT`=3, three consecutive conflicting ticks → `lockout`=1 after the third. A fourth tick with agreeing pa=pb=(1,1) → outputs (0,0).
- Two conflicting ticks then one agree tick → state NORMAL, `run`=0. A further two conflicts do not lock out.
- In LOCKOUT, `clear_lockout` and `tick_in` in the same cycle → that tick outputs (0,0), `lockout`=0 next cycle. The following agreeing tick with pa=(1,1) outputs (1,1).
- With `AB_CTRL_STATS_EN` and `CNT_W`=2, five ticks with `rec_pa`=1 → `rec_cnt_a` saturates at 3. Assert `rst_n`=0 mid-sequence → all outputs 0 immediately.
